// File: rtl/edac_pkg.sv
// Shared definitions for the 2x4-bit EDAC stage and its background scrubber:
// the uncorrectable marker, the CRC constant, decode-field positions and scrubber states.
package edac_pkg;

  localparam logic [31:0] DEFAULT_ERROR_CODE = 32'hFFFF_FFFF;
  localparam logic [7:0]  CRC_POLY           = 8'h97;

  // Field layout of a decode result; bits above HI_CORR_BIT are always zero
  localparam int LO_NIB_LSB  = 0;
  localparam int LO_CORR_BIT = 4;
  localparam int HI_NIB_LSB  = 5;
  localparam int HI_CORR_BIT = 9;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_DEC,
    S_DCHK,
    S_ENC,
    S_EWAIT,
    S_WR,
    S_DONE
  } scrub_state_e;

endpackage

// File: rtl/edac_scrub_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/edac_scrub_ctrl.sv
// Background scrubber: reads each word, decodes it through the EDAC, re-encodes and
// writes back corrected words, and counts/logs uncorrectable ones.
module edac_scrub_ctrl
  import edac_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          DEPTH      = 1024,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] ERROR_CODE = DEFAULT_ERROR_CODE
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_wdata,
  output logic              edac_en,
  output logic              edac_read,
  output logic [31:0]       edac_din,
  input  logic [31:0]       edac_dout,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] last_bad_addr
);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wb_q, wb_d;
  logic [ADDR_W-1:0] last_bad_q, last_bad_d;
  logic              cnt_clr;
  logic              corr_inc;
  logic              uncorr_inc;
  logic              last_word;

  assign last_word = (addr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    wb_d       = wb_q;
    last_bad_d = last_bad_q;
    cnt_clr    = 1'b0;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    edac_en    = 1'b0;
    edac_read  = 1'b0;
    edac_din   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_clr    = 1'b1;
          last_bad_d = '0;
          addr_d     = '0;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        mem_rd  = 1'b1;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        rdata_d = mem_rdata;
        state_d = S_DEC;
      end
      S_DEC: begin
        edac_en   = 1'b1;
        edac_read = 1'b1;
        edac_din  = rdata_q;
        state_d   = S_DCHK;
      end
      S_DCHK: begin
        if (edac_dout == ERROR_CODE) begin
          uncorr_inc = 1'b1;
          last_bad_d = addr_q;
        end else if (edac_dout[LO_CORR_BIT] || edac_dout[HI_CORR_BIT]) begin
          corr_inc = 1'b1;
        end
        if ((edac_dout != ERROR_CODE) && (edac_dout[LO_CORR_BIT] || edac_dout[HI_CORR_BIT])) begin
          state_d = S_ENC;
        end else if (last_word) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD;
        end
      end
      // EDAC output still holds the decode result here because edac_en was low in DCHK
      S_ENC: begin
        edac_en   = 1'b1;
        edac_read = 1'b0;
        edac_din  = {24'b0, edac_dout[HI_NIB_LSB +: 4], edac_dout[LO_NIB_LSB +: 4]};
        state_d   = S_EWAIT;
      end
      S_EWAIT: begin
        wb_d    = edac_dout;
        state_d = S_WR;
      end
      S_WR: begin
        mem_wr = 1'b1;
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rdata_q    <= '0;
      wb_q       <= '0;
      last_bad_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      wb_q       <= wb_d;
      last_bad_q <= last_bad_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_corr_cnt (
    .CLK   (CLK),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (corr_inc),
    .count (corr_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_uncorr_cnt (
    .CLK   (CLK),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (uncorr_inc),
    .count (uncorr_cnt)
  );

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wb_q;
  assign last_bad_addr = last_bad_q;

endmodule
